// File: rtl/board_controller.sv
// ---------------------------------------------------------------------------
// board_controller
//
// Game logic for a 5x5 WIN_LEN-in-a-row game, sitting directly upstream of
// the VGA renderer. Owns the board, the cursor and the turn order. Button
// inputs are single-cycle pulses from the debounce stage.
//
// Parameters:
//   WIN_LEN    contiguous same-player cells needed to win (3..5)
//   START_ROW  cursor row after reset/restart
//   START_COL  cursor column after reset/restart
//
// Ports:
//   clk             system clock, rising edge
//   clr             synchronous active-high reset
//   btn_up/down     cursor row -1 / +1 with wrap (both together: no move)
//   btn_left/right  cursor col -1 / +1 with wrap (both together: no move)
//   btn_place       place a piece in PLAY, restart in OVER
//   game_state      flattened board, cell (r,c) at bits [2*(5r+c)+1 : 2*(5r+c)]
//                   (0 empty, 1 player 1, 2 player 2)
//   cursor_row/col  cursor position, 0..4
//   current_player  player to move, 1 or 2
//   winner          0 none, 1/2 winning player, 3 draw
//   game_over       high while in OVER
//   move_count      pieces on the board, 0..25
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module board_controller #(
    parameter int unsigned WIN_LEN   = 4,
    parameter int unsigned START_ROW = 2,
    parameter int unsigned START_COL = 2
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_place,
    output logic [49:0] game_state,
    output logic [2:0]  cursor_row,
    output logic [2:0]  cursor_col,
    output logic [1:0]  current_player,
    output logic [1:0]  winner,
    output logic        game_over,
    output logic [4:0]  move_count
);

    typedef enum logic [1:0] {
        StPlay  = 2'd0,
        StCheck = 2'd1,
        StOver  = 2'd2
    } state_t;

    state_t state_q;

    // -----------------------------------------------------------------------
    // Cursor helpers
    // -----------------------------------------------------------------------

    // One-step move along an axis with wrap-around; opposing pulses cancel.
    function automatic logic [2:0] step_pos(input logic [2:0] pos,
                                            input logic       dec,
                                            input logic       inc);
        logic [2:0] res;
        res = pos;
        if (dec && !inc) begin
            res = (pos == 3'd0) ? 3'd4 : pos - 3'd1;
        end else if (inc && !dec) begin
            res = (pos == 3'd4) ? 3'd0 : pos + 3'd1;
        end
        return res;
    endfunction

    logic [4:0] cell_idx;
    logic [1:0] cursor_cell;
    logic [2:0] row_next;
    logic [2:0] col_next;

    always_comb begin
        cell_idx    = 5'(cursor_row) * 5'd5 + 5'(cursor_col);
        cursor_cell = game_state[{cell_idx, 1'b0} +: 2];
        row_next    = step_pos(cursor_row, btn_up, btn_down);
        col_next    = step_pos(cursor_col, btn_left, btn_right);
    end

    // -----------------------------------------------------------------------
    // Win detection on the registered board
    // -----------------------------------------------------------------------

    // True when the WIN_LEN cells starting at (r0,c0) stepping by (dr,dc)
    // all lie on the board and all hold player p. Windows that run off the
    // board are simply never a hit, so the caller can sweep every origin.
    function automatic logic window_hit(input logic [49:0] b,
                                        input int          r0,
                                        input int          c0,
                                        input int          dr,
                                        input int          dc,
                                        input logic [1:0]  p);
        logic hit;
        int   r;
        int   c;
        hit = 1'b1;
        for (int k = 0; k < 5; k++) begin
            if (k < int'(WIN_LEN)) begin
                r = r0 + k * dr;
                c = c0 + k * dc;
                if (r < 0 || r > 4 || c < 0 || c > 4) begin
                    hit = 1'b0;
                end else if (b[2 * (5 * r + c) +: 2] != p) begin
                    hit = 1'b0;
                end
            end
        end
        return hit;
    endfunction

    logic win_found;

    always_comb begin
        win_found = 1'b0;
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (window_hit(game_state, r, c, 0, 1, current_player) ||
                    window_hit(game_state, r, c, 1, 0, current_player) ||
                    window_hit(game_state, r, c, 1, 1, current_player) ||
                    window_hit(game_state, r, c, 1, -1, current_player)) begin
                    win_found = 1'b1;
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Game FSM and all output registers
    // -----------------------------------------------------------------------

    logic restart;
    assign restart = clr || (state_q == StOver && btn_place);

    always_ff @(posedge clk) begin
        if (restart) begin
            state_q        <= StPlay;
            game_state     <= '0;
            cursor_row     <= 3'(START_ROW);
            cursor_col     <= 3'(START_COL);
            current_player <= 2'd1;
            winner         <= 2'd0;
            game_over      <= 1'b0;
            move_count     <= 5'd0;
        end else begin
            unique case (state_q)
                StPlay: begin
                    if (btn_place && cursor_cell == 2'd0) begin
                        // Legal place: cursor pulses this cycle are dropped.
                        game_state[{cell_idx, 1'b0} +: 2] <= current_player;
                        move_count <= move_count + 5'd1;
                        state_q    <= StCheck;
                    end else begin
                        cursor_row <= row_next;
                        cursor_col <= col_next;
                    end
                end
                StCheck: begin
                    // A win on the last free cell takes precedence over draw.
                    if (win_found) begin
                        winner    <= current_player;
                        game_over <= 1'b1;
                        state_q   <= StOver;
                    end else if (move_count == 5'd25) begin
                        winner    <= 2'd3;
                        game_over <= 1'b1;
                        state_q   <= StOver;
                    end else begin
                        current_player <= (current_player == 2'd1) ? 2'd2 : 2'd1;
                        state_q        <= StPlay;
                    end
                end
                StOver: begin
                    // Everything frozen; restart handled above.
                end
                default: begin
                    state_q <= StPlay;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_board_controller.sv
module tb_board_controller;

    logic        clk = 1'b0;
    logic        clr = 1'b0;
    logic        btn_up = 1'b0;
    logic        btn_down = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_place = 1'b0;
    logic [49:0] game_state;
    logic [2:0]  cursor_row;
    logic [2:0]  cursor_col;
    logic [1:0]  current_player;
    logic [1:0]  winner;
    logic        game_over;
    logic [4:0]  move_count;

    board_controller #(
        .WIN_LEN  (4),
        .START_ROW(2),
        .START_COL(2)
    ) dut (
        .clk           (clk),
        .clr           (clr),
        .btn_up        (btn_up),
        .btn_down      (btn_down),
        .btn_left      (btn_left),
        .btn_right     (btn_right),
        .btn_place     (btn_place),
        .game_state    (game_state),
        .cursor_row    (cursor_row),
        .cursor_col    (cursor_col),
        .current_player(current_player),
        .winner        (winner),
        .game_over     (game_over),
        .move_count    (move_count)
    );

    always #5 clk = ~clk;

    // Scoreboard of expected observations.
    typedef struct {
        string       tag;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;

    // Reference model of the game.
    logic [1:0] mb[25];
    int         mrow;
    int         mcol;
    logic [1:0] mplayer;
    int         mcount;

    function automatic logic [63:0] observe(input int sel);
        case (sel)
            0:       return 64'(game_state);
            1:       return 64'(cursor_row);
            2:       return 64'(cursor_col);
            3:       return 64'(current_player);
            4:       return 64'(winner);
            5:       return 64'(game_over);
            default: return 64'(move_count);
        endcase
    endfunction

    function automatic logic [63:0] packed_board();
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < 25; i++) b[2 * i +: 2] = mb[i];
        return b;
    endfunction

    task automatic push(input string tag, input int sel, input logic [63:0] e);
        exp_t x;
        x.tag = tag;
        x.sel = sel;
        x.exp = e;
        sb.push_back(x);
    endtask

    task automatic drain();
        exp_t        x;
        logic [63:0] o;
        while (sb.size() > 0) begin
            x = sb.pop_front();
            o = observe(x.sel);
            total++;
            assert (o === x.exp) passed++;
            else $error("FAIL %s observed=%0h expected=%0h", x.tag, o, x.exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 25; i++) mb[i] = 2'd0;
        mrow    = 2;
        mcol    = 2;
        mplayer = 2'd1;
        mcount  = 0;
    endtask

    task automatic expect_state(input string tag, input logic [1:0] w, input logic go);
        push({tag, "_board"}, 0, packed_board());
        push({tag, "_row"}, 1, 64'(mrow));
        push({tag, "_col"}, 2, 64'(mcol));
        push({tag, "_player"}, 3, 64'(mplayer));
        push({tag, "_winner"}, 4, 64'(w));
        push({tag, "_over"}, 5, 64'(go));
        push({tag, "_count"}, 6, 64'(mcount));
        drain();
    endtask

    // Assert the given buttons for exactly one sampling edge.
    task automatic press(input logic u, input logic d, input logic l, input logic r,
                         input logic p);
        @(negedge clk);
        btn_up    = u;
        btn_down  = d;
        btn_left  = l;
        btn_right = r;
        btn_place = p;
        @(negedge clk);
        btn_up    = 1'b0;
        btn_down  = 1'b0;
        btn_left  = 1'b0;
        btn_right = 1'b0;
        btn_place = 1'b0;
    endtask

    task automatic do_clr(input string tag);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        model_reset();
        expect_state(tag, 2'd0, 1'b0);
    endtask

    task automatic move_to(input int r, input int c);
        while (mrow != r) begin
            press(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            mrow = (mrow + 1) % 5;
        end
        while (mcol != c) begin
            press(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
            mcol = (mcol + 1) % 5;
        end
        push("move_row", 1, 64'(mrow));
        push("move_col", 2, 64'(mcol));
        drain();
    endtask

    // Place at (r,c); w is the winner expected once CHECK has resolved.
    task automatic place_at(input int r, input int c, input logic [1:0] w);
        move_to(r, c);
        mb[r * 5 + c] = mplayer;
        mcount++;
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_state("place", 2'd0, 1'b0);
        @(negedge clk);
        if (w == 2'd0) mplayer = 2'd3 - mplayer;
        expect_state("check", w, w != 2'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    int e_row[5];
    int ones[$];
    int twos[$];

    initial begin
        e_row = '{1, 1, 2, 2, 1};

        // Reset and wrap.
        do_clr("reset");
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("wrap_row1", 1, 64'd1);
        drain();
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("wrap_row0", 1, 64'd0);
        drain();
        press(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        push("wrap_row4", 1, 64'd4);
        drain();
        mrow = 4;
        press(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        push("lr_cancel_col", 2, 64'd2);
        drain();
        press(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        push("ud_cancel_row", 1, 64'd4);
        drain();

        // Place and turn, then illegal re-place on the same cell.
        place_at(2, 2, 2'd0);
        push("cell22", 0, 64'(2'd1) << 24);
        drain();
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        expect_state("occupied", 2'd0, 1'b0);
        @(negedge clk);
        expect_state("occupied_after", 2'd0, 1'b0);

        // Horizontal win for player 1.
        do_clr("reset2");
        place_at(0, 0, 2'd0);
        place_at(4, 0, 2'd0);
        place_at(0, 1, 2'd0);
        place_at(4, 1, 2'd0);
        place_at(0, 2, 2'd0);
        place_at(4, 2, 2'd0);
        place_at(0, 3, 2'd1);
        press(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        expect_state("over_frozen", 2'd1, 1'b1);

        // Restart via btn_place.
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_reset();
        expect_state("restart", 2'd0, 1'b0);

        // Anti-diagonal win for player 2.
        place_at(0, 0, 2'd0);
        place_at(0, 4, 2'd0);
        place_at(0, 1, 2'd0);
        place_at(1, 3, 2'd0);
        place_at(1, 0, 2'd0);
        place_at(2, 2, 2'd0);
        place_at(4, 4, 2'd0);
        place_at(3, 1, 2'd2);
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_reset();
        expect_state("restart2", 2'd0, 1'b0);

        // Draw: alternating row pattern with no four-in-a-row anywhere.
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                if (((r % 2 == 0) ? e_row[c] : 3 - e_row[c]) == 1) ones.push_back(r * 5 + c);
                else twos.push_back(r * 5 + c);
            end
        end
        for (int i = 0; i < 13; i++) begin
            place_at(ones[i] / 5, ones[i] % 5, (i == 12) ? 2'd3 : 2'd0);
            if (i < 12) place_at(twos[i] / 5, twos[i] % 5, 2'd0);
        end
        push("draw_count", 6, 64'd25);
        drain();

        // Restart, then clr together with a legal place: reset wins.
        press(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        model_reset();
        expect_state("restart3", 2'd0, 1'b0);
        move_to(1, 1);
        @(negedge clk);
        clr       = 1'b1;
        btn_place = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        btn_place = 1'b0;
        model_reset();
        expect_state("clr_prio", 2'd0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
